inst_mem_server: RTL and testbench
==================================

Name: inst_mem_server

Overview:
- Instruction-memory responder for the fetch stage. The fetch stage issues a word fetch request; this block returns the instruction after a configurable number of wait states.
- It drives a freeze indication so fetch holds its PC while a fetch is pending.
- It supports branch-flush abort of an in-flight fetch.
- It has a load port for writing program words before or during a run.

Parameters:
- DEPTH, 64, number of 32-bit instruction words (word index 0..DEPTH-1).
- WAIT_STATES, 2, extra cycles per fetch, legal 0..15. Fetch latency is WAIT_STATES+1 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  fetch request, sampled only in IDLE.
- addr  in  32  byte address of fetch, captured with req.
- abort  in  1  branch flush; cancels a pending fetch.
- load_en  in  1  write enable for the program-load port.
- load_addr  in  32  word index for the load write.
- load_data  in  32  instruction word to write.
- rdata  out  32  fetched instruction, valid while ready=1.
- ready  out  1  one-cycle response pulse.
- err  out  1  fetch error flag, valid with ready.
- busy  out  1  fetch in flight (state != IDLE).
- freeze  out  1  combinational: ~ready & (req | busy).

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE immediately; wait counter is 0.
  - rdata=0, ready=0, err=0, busy=0.
  - Memory contents are not cleared and are retained across reset.
- FSM states: IDLE, WAIT.
  - IDLE: if req=1 and abort=0 at a rising edge, capture addr and load cnt=WAIT_STATES, then go to WAIT. Otherwise stay in IDLE.
  - WAIT, cnt!=0: decrement cnt.
  - WAIT, cnt==0: at that edge register the response, then return to IDLE:
    - rdata=mem[addr[31:2]];
    - ready=1;
    - err as defined in the error rules below.
- Latency: req sampled at edge E0 gives ready=1 in the cycle after edge E0+WAIT_STATES+1.
  - WAIT_STATES=0 gives ready in the cycle after the edge following the request edge.
- ready, rdata, err:
  - ready and err are registered and high for exactly one cycle.
  - rdata holds its last value until the next response.
- Back-to-back fetches: in the ready cycle the state is IDLE, so req can be accepted at the next edge. Maximum throughput is one fetch per WAIT_STATES+2 cycles.
- abort has priority in every state:
  - At an edge with abort=1, the state goes to IDLE, cnt is cleared and ready=0.
  - No response is produced for the cancelled fetch, and a req in the same cycle is ignored.
  - abort in IDLE with no fetch pending is a no-op.
- Errors:
  - If the captured addr[31:2] >= DEPTH, or addr[1:0] != 0, the response gives rdata=0 and err=1 (with ready=1).
  - The misaligned check is evaluated first; word index is still addr[31:2].
- Load port:
  - At an edge with load_en=1 and load_addr < DEPTH, write mem[load_addr] <= load_data.
  - Out-of-range load_addr is silently ignored.
  - Loads are accepted in any state and do not affect the FSM.
- Load/read collision: a load and a response read of the same word at the same edge returns the OLD contents in rdata. The new contents are visible to later fetches.
- freeze: combinational, no register. It is high from the cycle req is asserted until, but not including, the ready cycle.
- req while busy is ignored. The fetch stage must hold req until it sees ready.

Test Plan:
- Basic fetch with WAIT_STATES=2:
  - Stimulus: load mem[5]=0xE3A00014, then req with addr=20, sampled at edge E0.
  - Required: ready=1, rdata=0xE3A00014, err=0 in the cycle after edge E0+3; ready is 0 in the two preceding cycles.
- freeze and busy during a fetch:
  - freeze=1 and busy=1 in the cycles between E0 and the ready cycle, and in the cycle req is first asserted.
  - freeze=0 in the ready cycle.
- Abort mid-fetch:
  - Stimulus: req with addr=8; abort=1 one cycle later during WAIT.
  - Required: busy=0 next cycle, no ready pulse ever appears.
  - Follow-up: a new req with addr=12 returns mem[3] with normal latency.
- Error cases, DEPTH=64:
  - addr=256 gives ready=1, err=1, rdata=0.
  - addr=0x00000006 gives err=1, rdata=0.
  - load_addr=70 with load_en=1 leaves all of memory unchanged.
- Zero wait states and back-to-back, WAIT_STATES=0:
  - Stimulus: req held high with addr=0, then addr=4.
  - Required: ready pulses on alternate cycles, returning mem[0] then mem[1].
- Reset mid-operation:
  - Stimulus: rst=0 asserted between edges while in WAIT.
  - Required: ready, busy, err and rdata are 0 immediately, without waiting for a clock edge.
  - After release, a fetch of addr=20 still returns the pre-reset contents 0xE3A00014.

Source files
------------

// File: rtl/inst_mem_server.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_server
//  Description : Instruction-memory responder for the fetch stage. Accepts a
//                word fetch, returns the instruction after WAIT_STATES extra
//                cycles, drives a freeze indication while a fetch is pending,
//                supports branch-flush abort and a program-load write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_server #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        abort,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic        freeze
);

    // Index width for the storage array; a one-word memory still needs a bit.
    localparam int          c_aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] c_depth_w = 30'(DEPTH);
    localparam logic [31:0] c_depth_l = 32'(DEPTH);
    localparam logic [3:0]  c_wait    = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;

    // Program storage; deliberately not reset so contents survive rst.
    logic [31:0] mem_q [DEPTH];

    logic [29:0] w_word;
    logic        w_misalign;
    logic        w_oob;
    logic        w_resp_err;
    logic [31:0] w_resp_data;
    logic        w_load_ok;

    // Response decode from the captured fetch address. The misaligned case
    // is checked first, but either fault yields the same zeroed error reply.
    always_comb begin
        w_word      = addr_q[31:2];
        w_misalign  = (addr_q[1:0] != 2'b00);
        w_oob       = (w_word >= c_depth_w);
        w_resp_err  = w_misalign | w_oob;
        w_resp_data = 32'h0;
        if (!w_resp_err) begin
            w_resp_data = mem_q[w_word[c_aw-1:0]];
        end
    end

    assign w_load_ok = load_en & (load_addr < c_depth_l);

    // Program-load write port; out-of-range indices are dropped. A read of
    // the same word at the same edge sees the old contents (NBA ordering).
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            mem_q[load_addr[c_aw-1:0]] <= load_data;
        end
    end

    // Fetch FSM with registered response; abort overrides every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // ready/err are single-cycle pulses; rdata holds between replies.
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                cnt_q   <= 4'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req) begin
                            addr_q  <= addr;
                            cnt_q   <= c_wait;
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            rdata_q <= w_resp_data;
                            ready_q <= 1'b1;
                            err_q   <= w_resp_err;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign rdata  = rdata_q;
    assign ready  = ready_q;
    assign err    = err_q;
    assign busy   = (state_q == ST_WAIT);
    // Fetch must hold its PC from request until the response arrives.
    assign freeze = ~ready_q & (req | busy);

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_server
//  Description : Self-checking bench for inst_mem_server. Two instances
//                (WAIT_STATES=2 and WAIT_STATES=0) share one stimulus stream
//                and are compared every cycle against an edge-count based
//                reference model, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_server;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        abort = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;

    logic [31:0] rdata_w  [2];
    logic        ready_w  [2];
    logic        err_w    [2];
    logic        busy_w   [2];
    logic        freeze_w [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_mem_server #(.DEPTH(64), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .abort(abort),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .rdata(rdata_w[0]), .ready(ready_w[0]), .err(err_w[0]),
        .busy(busy_w[0]), .freeze(freeze_w[0])
    );

    inst_mem_server #(.DEPTH(64), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .abort(abort),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .rdata(rdata_w[1]), .ready(ready_w[1]), .err(err_w[1]),
        .busy(busy_w[1]), .freeze(freeze_w[1])
    );

    // ---------------- reference model ----------------
    // A fetch accepted at edge n answers at edge n+WAIT_STATES+1 unless an
    // abort edge intervenes.
    int          ws_of [2] = '{2, 0};
    logic [31:0] ref_mem [64];
    bit          m_busy  [2] = '{0, 0};
    longint      m_due   [2] = '{0, 0};
    logic [31:0] m_addr  [2] = '{32'h0, 32'h0};
    bit          m_ready [2] = '{0, 0};
    bit          m_err   [2] = '{0, 0};
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
    longint      n_edge = 0;

    always @(negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 0;
            m_ready[k] = 0;
            m_err[k]   = 0;
            m_rdata[k] = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            n_edge++;
            for (int k = 0; k < 2; k++) begin
                m_ready[k] = 0;
                m_err[k]   = 0;
                if (abort) begin
                    m_busy[k] = 0;
                end else if (m_busy[k]) begin
                    if (n_edge == m_due[k]) begin
                        bit          e;
                        int unsigned w;
                        w = m_addr[k] >> 2;
                        e = (m_addr[k] % 4 != 0) || (w >= 64);
                        m_ready[k] = 1;
                        m_err[k]   = e;
                        m_rdata[k] = e ? 32'h0 : ref_mem[w];
                        m_busy[k]  = 0;
                    end
                end else if (req) begin
                    m_busy[k] = 1;
                    m_due[k]  = n_edge + ws_of[k] + 1;
                    m_addr[k] = addr;
                end
            end
            if (load_en && load_addr < 64) ref_mem[load_addr] = load_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready[%0d]", k),  32'(ready_w[k]),  32'(m_ready[k]));
            chk($sformatf("err[%0d]", k),    32'(err_w[k]),    32'(m_err[k]));
            chk($sformatf("rdata[%0d]", k),  rdata_w[k],       m_rdata[k]);
            chk($sformatf("busy[%0d]", k),   32'(busy_w[k]),   32'(m_busy[k]));
            chk($sformatf("freeze[%0d]", k), 32'(freeze_w[k]),
                32'(!m_ready[k] && (req || m_busy[k])));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = 32'(a);
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // One-cycle request, then wait (bounded) for the WAIT_STATES=2 reply.
    // lat counts mid-cycle samples after the accepting edge.
    task automatic do_fetch(input logic [31:0] a, output logic [31:0] rd,
                            output logic e, output int lat);
        req  = 1'b1;
        addr = a;
        tick();
        req = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready_w[0]) begin
                lat = i;
                break;
            end
        end
        rd = rdata_w[0];
        e  = err_w[0];
        tick();
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;

    initial begin
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("reset_busy",  32'(busy_w[0]),  32'h0);
        chk("reset_ready", 32'(ready_w[0]), 32'h0);
        chk("reset_rdata", rdata_w[0],      32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 64; i++) load(i, $urandom);
        load(0, 32'hA0A0_0001);
        load(1, 32'hB0B0_0002);
        load(3, 32'h3333_4444);
        load(5, 32'hE3A0_0014);
        load(6, 32'h6666_7777);

        // Basic fetch
        do_fetch(32'd20, rd, e, lat);
        chk("basic_latency", 32'(lat), 32'd4);
        chk("basic_rdata", rd, 32'hE3A0_0014);
        chk("basic_err", 32'(e), 32'h0);

        // Abort mid-fetch
        req = 1'b1; addr = 32'd8;
        tick();
        req = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy_w[0]), 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(ready_w[0]), 32'h0);
        end
        tick();
        do_fetch(32'd12, rd, e, lat);
        chk("after_abort_latency", 32'(lat), 32'd4);
        chk("after_abort_rdata", rd, 32'h3333_4444);

        // Error cases
        do_fetch(32'd256, rd, e, lat);
        chk("oob_latency", 32'(lat), 32'd4);
        chk("oob_err", 32'(e), 32'h1);
        chk("oob_rdata", rd, 32'h0);
        do_fetch(32'h6, rd, e, lat);
        chk("misalign_err", 32'(e), 32'h1);
        chk("misalign_rdata", rd, 32'h0);
        load(70, 32'hDEAD_BEEF);
        do_fetch(32'd24, rd, e, lat);
        chk("oob_load_word6", rd, 32'h6666_7777);
        do_fetch(32'd0, rd, e, lat);
        chk("oob_load_word0", rd, 32'hA0A0_0001);

        // Back-to-back on the zero-wait instance
        req = 1'b1; addr = 32'd0;
        @(posedge clk); #2 addr = 32'd4;
        @(negedge clk); chk("b2b_ready_c1", 32'(ready_w[1]), 32'h0);
        @(negedge clk); chk("b2b_ready_c2", 32'(ready_w[1]), 32'h1);
        chk("b2b_rdata_0", rdata_w[1], 32'hA0A0_0001);
        @(negedge clk); chk("b2b_ready_c3", 32'(ready_w[1]), 32'h0);
        #1 req = 1'b0;
        @(negedge clk); chk("b2b_ready_c4", 32'(ready_w[1]), 32'h1);
        chk("b2b_rdata_1", rdata_w[1], 32'hB0B0_0002);
        repeat (6) tick();

        // Asynchronous reset while in WAIT
        req = 1'b1; addr = 32'd20;
        tick();
        req = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("arst_ready", 32'(ready_w[0]), 32'h0);
        chk("arst_busy",  32'(busy_w[0]),  32'h0);
        chk("arst_err",   32'(err_w[0]),   32'h0);
        chk("arst_rdata", rdata_w[0],      32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        do_fetch(32'd20, rd, e, lat);
        chk("post_reset_latency", 32'(lat), 32'd4);
        chk("post_reset_rdata", rd, 32'hE3A0_0014);

        // Load/read collision on the response edge
        req = 1'b1; addr = 32'd20;
        tick();
        req = 1'b0;
        tick();
        tick();
        load_en = 1'b1; load_addr = 32'd5; load_data = 32'h1111_2222;
        tick();
        load_en = 1'b0;
        @(negedge clk);
        chk("collide_ready", 32'(ready_w[0]), 32'h1);
        chk("collide_old", rdata_w[0], 32'hE3A0_0014);
        tick();
        do_fetch(32'd20, rd, e, lat);
        chk("collide_new", rd, 32'h1111_2222);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            req   = ($urandom_range(0, 1) == 1);
            abort = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0:       addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
                1:       addr = $urandom;
                default: addr = 32'($urandom_range(0, 63)) << 2;
            endcase
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = 32'($urandom_range(0, 79));
            load_data = $urandom;
            tick();
        end
        req = 1'b0; abort = 1'b0; load_en = 1'b0;
        repeat (25) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
